// File: rtl/ac97_capture_fifo.sv
// Stereo capture FIFO between the AC'97 datapath and the processing stage (FWFT, valid/ready).
// Optional peak metering is compiled in when AC97_FIFO_PEAK_EN is defined.
module ac97_capture_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SAMPLE_W   = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready_sig,
    input  logic [SAMPLE_W-1:0]   cap_left,
    input  logic [SAMPLE_W-1:0]   cap_right,
    input  logic                  flush,
    output logic [SAMPLE_W-1:0]   samp_left,
    output logic [SAMPLE_W-1:0]   samp_right,
    output logic                  samp_valid,
    input  logic                  samp_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [SAMPLE_W-2:0]   peak_left,
    output logic [SAMPLE_W-2:0]   peak_right,
    input  logic                  peak_clr
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   FILL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PAIR_W-1:0]     mem [DEPTH];
    logic                  ready_q_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   fill_reg, fill_next;
    logic [PAIR_W-1:0]     head_reg, head_next;
    logic                  head_load;
    logic                  overflow_reg;
    logic                  wr_stb, is_full, is_empty;
    logic                  pop, wr_en, drop;
    logic [PAIR_W-1:0]     wr_pair;

    assign wr_stb   = ready_sig & ~ready_q_reg;
    assign is_full  = (fill_reg == FULL_LEVEL);
    assign is_empty = (fill_reg == '0);
    assign wr_pair  = {cap_left, cap_right};

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    always_comb begin
        pop   = 1'b0;
        wr_en = 1'b0;
        drop  = 1'b0;
        if (!flush) begin
            pop   = !is_empty && samp_ready;
            wr_en = wr_stb && (!is_full || pop);
            drop  = wr_stb && is_full && !pop;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        fill_next   = fill_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            fill_next   = '0;
        end else begin
            if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (pop)   rd_ptr_next = rd_ptr_reg + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   fill_next = fill_reg + FILL_ONE;
                2'b01:   fill_next = fill_reg - FILL_ONE;
                default: fill_next = fill_reg;
            endcase
        end
    end

    // Head register reads the next head slot; the incoming pair is forwarded when it
    // becomes the head in the same cycle it is written. Outputs hold while empty.
    always_comb begin
        head_load = !flush && (fill_next != '0);
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = wr_pair;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_pair;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            ready_q_reg <= ready_sig;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            fill_reg    <= fill_next;
            if (head_load) begin
                head_reg <= head_next;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign samp_left  = head_reg[PAIR_W-1:SAMPLE_W];
    assign samp_right = head_reg[SAMPLE_W-1:0];
    assign samp_valid = !is_empty;
    assign fill_level = fill_reg;
    assign overflow   = overflow_reg;

`ifdef AC97_FIFO_PEAK_EN
    localparam logic [SAMPLE_W-1:0] SAMP_ONE = {{(SAMPLE_W-1){1'b0}}, 1'b1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_peak
        logic [SAMPLE_W-1:0] sample;
        logic [SAMPLE_W-1:0] neg;
        logic [SAMPLE_W-2:0] mag;
        logic [SAMPLE_W-2:0] peak_reg;

        assign sample = (gi == 0) ? cap_left : cap_right;
        assign neg    = ~sample + SAMP_ONE;

        // Negating the most negative code overflows; it saturates to the largest magnitude.
        always_comb begin
            if (!sample[SAMPLE_W-1]) begin
                mag = sample[SAMPLE_W-2:0];
            end else if (neg[SAMPLE_W-1]) begin
                mag = '1;
            end else begin
                mag = neg[SAMPLE_W-2:0];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                peak_reg <= '0;
            end else if (peak_clr) begin
                peak_reg <= wr_en ? mag : '0;
            end else if (wr_en && (mag > peak_reg)) begin
                peak_reg <= mag;
            end
        end
    end

    assign peak_left  = g_peak[0].peak_reg;
    assign peak_right = g_peak[1].peak_reg;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_left       = '0;
    assign peak_right      = '0;
`endif

endmodule

// File: tb/tb_ac97_capture_fifo.sv
// Scoreboard bench for ac97_capture_fifo: stimulus pushes expected pairs, a negedge monitor pops and compares.
module tb_ac97_capture_fifo;
    localparam int SW = 18;

`ifdef AC97_FIFO_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, ready_sig, flush, samp_ready, ovf_clr, peak_clr;
    logic [SW-1:0] cap_left, cap_right, samp_left, samp_right;
    logic          samp_valid, overflow;
    logic [4:0]    fill_level;
    logic [SW-2:0] peak_left, peak_right;

    int vectors     = 0;
    int miscompares = 0;
    int pop_count   = 0;
    logic [2*SW-1:0] sb_q [$];

    ac97_capture_fifo #(.DEPTH_LOG2(4), .SAMPLE_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ready_sig  (ready_sig),
        .cap_left   (cap_left),
        .cap_right  (cap_right),
        .flush      (flush),
        .samp_left  (samp_left),
        .samp_right (samp_right),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .fill_level (fill_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .peak_left  (peak_left),
        .peak_right (peak_right),
        .peak_clr   (peak_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*SW-1:0] act, input logic [2*SW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [SW-2:0] pk(input logic [SW-2:0] v);
        return PEAK_ON ? v : '0;
    endfunction

    // Monitor: a pop happens at the next posedge whenever valid && ready and no flush.
    initial forever begin
        @(negedge clk);
        if (!reset && !flush && samp_valid && samp_ready) begin
            pop_count++;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got %h, expected no pop", {samp_left, samp_right});
            end else begin
                check("pop_data", {samp_left, samp_right}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // One frame: ready_sig held 3 cycles; side controls are active only in the strobe cycle.
    task automatic frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit accept,
                         input bit rdy, input bit pclr, input bit fl, input bit oclr, input bit chk_lat);
        logic old_rdy;
        @(posedge clk); #1;
        cap_left  = l;
        cap_right = r;
        ready_sig = 1'b1;
        old_rdy   = samp_ready;
        if (rdy) samp_ready = 1'b1;
        peak_clr = pclr;
        flush    = fl;
        ovf_clr  = oclr;
        if (accept) sb_q.push_back({l, r});
        if (chk_lat) check("valid_before_strobe", {35'd0, samp_valid}, 36'd0);
        @(posedge clk); #1;
        peak_clr   = 1'b0;
        flush      = 1'b0;
        ovf_clr    = 1'b0;
        samp_ready = old_rdy;
        if (chk_lat) check("valid_after_strobe", {35'd0, samp_valid}, 36'd1);
        repeat (2) @(posedge clk);
        #1 ready_sig = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        samp_ready = 1'b1;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 samp_ready = 1'b0;
        check("drain_queue_left", 36'(sb_q.size()), 36'd0);
        check("drain_fill", 36'(fill_level), 36'd0);
    endtask

    initial begin
        int base;
        logic [SW-1:0] l;
        reset = 1'b1; ready_sig = 1'b0; flush = 1'b0; samp_ready = 1'b0;
        ovf_clr = 1'b0; peak_clr = 1'b0; cap_left = '0; cap_right = '0;
        #1;
        check("rst_fill", 36'(fill_level), 36'd0);
        check("rst_valid", {35'd0, samp_valid}, 36'd0);
        check("rst_data", {samp_left, samp_right}, 36'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // T1: reset in the middle of a stream
        for (int i = 0; i < 5; i++) frame(SW'(i + 10), SW'(i + 20), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_fill5", 36'(fill_level), 36'd5);
        check("t1_head", {samp_left, samp_right}, {18'd10, 18'd20});
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("t1_fill", 36'(fill_level), 36'd0);
        check("t1_valid", {35'd0, samp_valid}, 36'd0);
        check("t1_data", {samp_left, samp_right}, 36'd0);
        check("t1_ovf", {35'd0, overflow}, 36'd0);
        check("t1_peak", {1'b0, peak_left, 1'b0, peak_right}, 36'd0);
        sb_q.delete();
        @(posedge clk); #1 reset = 1'b0;

        // T2: two frames with consumer always ready
        base = pop_count;
        samp_ready = 1'b1;
        frame(18'h00001, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(18'h1FFFF, 18'h20000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("t2_pops", 36'(pop_count - base), 36'd2);
        check("t2_valid_low", {35'd0, samp_valid}, 36'd0);
        check("t2_hold", {samp_left, samp_right}, {18'h1FFFF, 18'h20000});
        samp_ready = 1'b0;

        // T3: fill to 16, 17th dropped (ovf_clr coincident with the drop: set wins)
        for (int i = 0; i < 16; i++) begin
            l = SW'(i * 4099 + 1);
            frame(l, ~l, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("t3_fill16", 36'(fill_level), 36'd16);
        check("t3_ovf0", {35'd0, overflow}, 36'd0);
        frame(18'h12345, 18'h23456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_fill_after_drop", 36'(fill_level), 36'd16);
        check("t3_ovf1", {35'd0, overflow}, 36'd1);
        drain();
        check("t3_ovf_sticky", {35'd0, overflow}, 36'd1);

        // T5: flush with coincident strobe at fill 7
        for (int i = 0; i < 7; i++) frame(SW'(i * 77 + 5), SW'(i * 91 + 3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_fill7", 36'(fill_level), 36'd7);
        frame(18'h0ABCD, 18'h0DCBA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sb_q.delete();
        check("t5_fill0", 36'(fill_level), 36'd0);
        check("t5_valid0", {35'd0, samp_valid}, 36'd0);
        check("t5_ovf_kept", {35'd0, overflow}, 36'd1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_clr", {35'd0, overflow}, 36'd0);

        // T4: full, then write and pop in the same cycle
        for (int i = 0; i < 16; i++) frame(SW'(i * 1000 + 7), SW'(i * 333), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_fill16", 36'(fill_level), 36'd16);
        frame(18'h2AAAA, 18'h15555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_fill_still16", 36'(fill_level), 36'd16);
        check("t4_ovf0", {35'd0, overflow}, 36'd0);
        drain();

        // T6: peak metering
        samp_ready = 1'b1;
        @(posedge clk); #1 peak_clr = 1'b1;
        @(posedge clk); #1 peak_clr = 1'b0;
        check("t6_clr0", {1'b0, peak_left, 1'b0, peak_right}, 36'd0);
        frame(18'h3FFFB, 18'h00007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_peak_m5", {1'b0, peak_left, 1'b0, peak_right}, {1'b0, pk(17'd5), 1'b0, pk(17'd7)});
        frame(18'h00003, 18'h3FFF9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_peak_p3", {1'b0, peak_left, 1'b0, peak_right}, {1'b0, pk(17'd5), 1'b0, pk(17'd7)});
        frame(18'h20000, 18'h1FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_peak_sat", {1'b0, peak_left, 1'b0, peak_right}, {1'b0, pk(17'h1FFFF), 1'b0, pk(17'h1FFFF)});
        frame(18'h00002, 18'h3FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_clr_with_write", {1'b0, peak_left, 1'b0, peak_right}, {1'b0, pk(17'd2), 1'b0, pk(17'd2)});
        @(posedge clk); #1 peak_clr = 1'b1;
        @(posedge clk); #1 peak_clr = 1'b0;
        check("t6_clr_final", {1'b0, peak_left, 1'b0, peak_right}, 36'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
